// File: rtl/frv_interrupt_ctrl.sv
// rtl/frv_interrupt_ctrl.sv - prioritised external/timer/software/NMI interrupt controller with trap FSM
//
// Purpose:
//   Collects NSRC external sources (level or edge per EDGE_MASK), applies a
//   per-source priority, enable mask and global threshold, and exposes the
//   winning source through a CLAIM register.  External, software, timer and
//   NMI causes are arbitrated into a single trap request for writeback.
//
// Ports:
//   g_clk, g_reset                  clock; asynchronous active-high reset
//   src_irq[NSRC-1:0]               external interrupt lines (source i has id i+1)
//   nmi                             non-maskable interrupt, latched on its rising edge
//   mstatus_mie                     global interrupt enable
//   mie_meie, mie_mtie, mie_msie    external / timer / software enables
//   ti_pending, sw_pending          timer / software interrupt lines
//   cfg_en, cfg_wen                 register access strobe / write select
//   cfg_addr, cfg_wdata             byte address / write data
//   cfg_rdata, cfg_error            combinational read data / access error
//   mip_meip, mip_mtip, mip_msip    pending status
//   int_trap_req, int_trap_cause    trap request and its cause code
//   int_trap_ack                    trap acknowledge from writeback
module frv_interrupt_ctrl #(
  parameter int              NSRC      = 8,
  parameter int              PRIO_W    = 3,
  parameter logic [NSRC-1:0] EDGE_MASK = {NSRC{1'b0}}
) (
  input  logic            g_clk,
  input  logic            g_reset,
  input  logic [NSRC-1:0] src_irq,
  input  logic            nmi,
  input  logic            mstatus_mie,
  input  logic            mie_meie,
  input  logic            mie_mtie,
  input  logic            mie_msie,
  input  logic            ti_pending,
  input  logic            sw_pending,
  input  logic            cfg_en,
  input  logic            cfg_wen,
  input  logic [7:0]      cfg_addr,
  input  logic [31:0]     cfg_wdata,
  output logic [31:0]     cfg_rdata,
  output logic            cfg_error,
  output logic            mip_meip,
  output logic            mip_mtip,
  output logic            mip_msip,
  output logic            int_trap_req,
  output logic [5:0]      int_trap_cause,
  input  logic            int_trap_ack
);

  localparam int         ID_W      = 5;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REQ    = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;
  localparam logic [5:0] CAUSE_NMI = 6'd0;
  localparam logic [5:0] CAUSE_SW  = 6'd3;
  localparam logic [5:0] CAUSE_TIM = 6'd7;
  localparam logic [5:0] CAUSE_EXT = 6'd11;
  localparam logic [7:0] A_ENABLE  = 8'h80;
  localparam logic [7:0] A_PENDING = 8'h84;
  localparam logic [7:0] A_THRESH  = 8'h88;
  localparam logic [7:0] A_CLAIM   = 8'h8C;

  // Architectural state
  logic [PRIO_W-1:0] prio [NSRC];
  logic [NSRC-1:0]   enable;
  logic [NSRC-1:0]   pending;
  logic [NSRC-1:0]   src_q;
  logic [PRIO_W-1:0] threshold;
  logic              armed;
  logic              nmi_q;
  logic              nmi_pend;
  logic [1:0]        state;
  logic [5:0]        cause_q;

  // Register decode
  logic [4:0]        prio_idx;
  logic              is_prio;
  logic              is_enable;
  logic              is_pending;
  logic              is_thresh;
  logic              is_claim;
  logic              mapped;
  logic              acc_err;
  logic              wr_ok;
  logic              claim_rd;
  logic [31:0]       rdata;
  logic              unused_wdata;

  // Arbitration
  logic [NSRC-1:0]   eligible;
  logic [ID_W-1:0]   win_id;
  logic [PRIO_W-1:0] win_prio;
  logic [NSRC-1:0]   pending_nxt;
  logic              q_ext;
  logic              q_sw;
  logic              q_tim;
  logic              any_qual;
  logic [5:0]        take_cause;
  logic              held_live;

  assign unused_wdata = ^cfg_wdata;

  assign prio_idx   = cfg_addr[6:2];
  assign is_prio    = (cfg_addr[7] == 1'b0) && (cfg_addr[1:0] == 2'b00) && (int'(prio_idx) < NSRC);
  assign is_enable  = (cfg_addr == A_ENABLE);
  assign is_pending = (cfg_addr == A_PENDING);
  assign is_thresh  = (cfg_addr == A_THRESH);
  assign is_claim   = (cfg_addr == A_CLAIM);
  assign mapped     = is_prio | is_enable | is_pending | is_thresh | is_claim;

  // Errors are suppressed while reset is held so the outputs read as idle.
  assign acc_err   = cfg_en && !g_reset && (!mapped || (is_claim && cfg_wen));
  assign cfg_error = acc_err;
  assign wr_ok     = cfg_en && cfg_wen && !acc_err;
  assign claim_rd  = cfg_en && !cfg_wen && is_claim && !g_reset;

  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      eligible[i] = pending[i] && enable[i] && (prio[i] > threshold);
    end
  end

  // Ascending scan with a strict compare keeps the lowest index on ties.
  always_comb begin
    win_id   = '0;
    win_prio = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (eligible[i] && ((win_id == '0) || (prio[i] > win_prio))) begin
        win_id   = ID_W'(i + 1);
        win_prio = prio[i];
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (is_prio && (prio_idx == 5'(i))) begin
        rdata[PRIO_W-1:0] = prio[i];
      end
    end
    if (is_enable)  rdata[NSRC-1:0]   = enable;
    if (is_pending) rdata[NSRC-1:0]   = pending;
    if (is_thresh)  rdata[PRIO_W-1:0] = threshold;
    if (is_claim)   rdata[ID_W-1:0]   = win_id;
  end

  assign cfg_rdata = (cfg_en && !g_reset && !acc_err) ? rdata : 32'd0;

  // Level bits mirror the line; edge bits are sticky with set taking
  // precedence over a same-cycle claim or write-1 clear.  Edge detection is
  // held off for the first cycle after reset so a line already high does
  // not look like a fresh rising edge.
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      if (EDGE_MASK[i]) begin
        pending_nxt[i] = (armed && src_irq[i] && !src_q[i]) ||
                         (pending[i] &&
                          !((claim_rd && (win_id == ID_W'(i + 1))) ||
                            (wr_ok && is_pending && cfg_wdata[i])));
      end else begin
        pending_nxt[i] = src_irq[i];
      end
    end
  end

  assign mip_meip = |eligible;
  assign mip_mtip = ti_pending;
  assign mip_msip = sw_pending;

  assign q_ext = mstatus_mie && mie_meie && mip_meip;
  assign q_sw  = mstatus_mie && mie_msie && mip_msip;
  assign q_tim = mstatus_mie && mie_mtie && mip_mtip;

  always_comb begin
    any_qual   = 1'b1;
    take_cause = CAUSE_NMI;
    if (nmi_pend)   take_cause = CAUSE_NMI;
    else if (q_ext) take_cause = CAUSE_EXT;
    else if (q_sw)  take_cause = CAUSE_SW;
    else if (q_tim) take_cause = CAUSE_TIM;
    else            any_qual   = 1'b0;
  end

  // An NMI request stays valid until acknowledged.
  always_comb begin
    case (cause_q)
      CAUSE_EXT: held_live = q_ext;
      CAUSE_SW:  held_live = q_sw;
      CAUSE_TIM: held_live = q_tim;
      default:   held_live = 1'b1;
    endcase
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      for (int i = 0; i < NSRC; i++) begin
        prio[i] <= '0;
      end
      enable    <= '0;
      threshold <= '0;
      pending   <= '0;
      src_q     <= '0;
      armed     <= 1'b0;
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        if (wr_ok && is_prio && (prio_idx == 5'(i))) begin
          prio[i] <= cfg_wdata[PRIO_W-1:0];
        end
      end
      if (wr_ok && is_enable) enable    <= cfg_wdata[NSRC-1:0];
      if (wr_ok && is_thresh) threshold <= cfg_wdata[PRIO_W-1:0];
      pending <= pending_nxt;
      src_q   <= src_irq;
      armed   <= 1'b1;
    end
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      nmi_q    <= 1'b0;
      nmi_pend <= 1'b0;
    end else begin
      nmi_q <= nmi;
      if (nmi && !nmi_q) begin
        nmi_pend <= 1'b1;
      end else if ((state == ST_REQ) && int_trap_ack && (cause_q == CAUSE_NMI)) begin
        nmi_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state   <= ST_IDLE;
      cause_q <= CAUSE_NMI;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_qual) begin
            cause_q <= take_cause;
            state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (int_trap_ack) begin
            state <= ST_HOLD;
          end else if (!held_live) begin
            state <= ST_IDLE;
          end
        end
        ST_HOLD: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign int_trap_req   = (state == ST_REQ);
  assign int_trap_cause = cause_q;

endmodule

// File: tb/tb_frv_interrupt_ctrl.sv
// tb/tb_frv_interrupt_ctrl.sv - self-checking bench for frv_interrupt_ctrl
module tb_frv_interrupt_ctrl;

  localparam int         NSRC = 8;
  localparam int         PW   = 3;
  localparam logic [7:0] EDGE = 8'h01;

  logic        g_clk = 1'b0;
  logic        g_reset;
  logic [7:0]  src_irq;
  logic        nmi;
  logic        mstatus_mie, mie_meie, mie_mtie, mie_msie;
  logic        ti_pending, sw_pending;
  logic        cfg_en, cfg_wen;
  logic [7:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        cfg_error;
  logic        mip_meip, mip_mtip, mip_msip;
  logic        int_trap_req;
  logic [5:0]  int_trap_cause;
  logic        int_trap_ack;

  always #5 g_clk = ~g_clk;

  frv_interrupt_ctrl #(.NSRC(NSRC), .PRIO_W(PW), .EDGE_MASK(EDGE)) dut (
    .g_clk(g_clk), .g_reset(g_reset), .src_irq(src_irq), .nmi(nmi),
    .mstatus_mie(mstatus_mie), .mie_meie(mie_meie), .mie_mtie(mie_mtie), .mie_msie(mie_msie),
    .ti_pending(ti_pending), .sw_pending(sw_pending),
    .cfg_en(cfg_en), .cfg_wen(cfg_wen), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata), .cfg_error(cfg_error),
    .mip_meip(mip_meip), .mip_mtip(mip_mtip), .mip_msip(mip_msip),
    .int_trap_req(int_trap_req), .int_trap_cause(int_trap_cause), .int_trap_ack(int_trap_ack)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  int         m_prio [NSRC];
  logic [7:0] m_en, m_pend, m_srcq;
  int         m_thr;
  bit         m_armed, m_nmiq, m_nmip;
  int         m_phase;   // 0 idle, 1 requesting, 2 hold
  int         m_cause;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NSRC; i++) m_prio[i] = 0;
    m_en = 0; m_pend = 0; m_srcq = 0; m_thr = 0;
    m_armed = 0; m_nmiq = 0; m_nmip = 0; m_phase = 0; m_cause = 0;
  endtask

  // Highest priority level first, lowest index within that level.
  function automatic int m_winner();
    for (int p = 7; p >= 1; p--) begin
      if (p <= m_thr) break;
      for (int i = 0; i < NSRC; i++)
        if (m_pend[i] && m_en[i] && m_prio[i] == p) return i + 1;
    end
    return 0;
  endfunction

  function automatic bit m_mapped(int a);
    if (a % 4 != 0) return 0;
    if (a < 128) return (a / 4) < NSRC;
    return (a == 128) || (a == 132) || (a == 136) || (a == 140);
  endfunction

  function automatic bit m_err();
    int a = int'(cfg_addr);
    return cfg_en && (!m_mapped(a) || (a == 140 && cfg_wen));
  endfunction

  function automatic logic [31:0] m_read();
    int a = int'(cfg_addr);
    if (m_err()) return 0;
    if (a < 128) return m_prio[a / 4];
    if (a == 128) return {24'd0, m_en};
    if (a == 132) return {24'd0, m_pend};
    if (a == 136) return m_thr;
    return m_winner();
  endfunction

  function automatic bit m_qual(int c);
    case (c)
      0:  return m_nmip;
      11: return mstatus_mie && mie_meie && (m_winner() != 0);
      3:  return mstatus_mie && mie_msie && sw_pending;
      default: return mstatus_mie && mie_mtie && ti_pending;
    endcase
  endfunction

  task automatic check_outputs(string tag);
    chk({tag, ".req"},   int_trap_req, m_phase == 1);
    chk({tag, ".cause"}, int_trap_cause, m_cause);
    chk({tag, ".meip"},  mip_meip, m_winner() != 0);
    chk({tag, ".mtip"},  mip_mtip, ti_pending);
    chk({tag, ".msip"},  mip_msip, sw_pending);
    chk({tag, ".err"},   cfg_error, m_err());
    if (!cfg_en) chk({tag, ".rdata0"}, cfg_rdata, 0);
    else if (!cfg_wen) chk({tag, ".rdata"}, cfg_rdata, m_read());
  endtask

  task automatic model_step();
    int         w     = m_winner();
    bit         err   = m_err();
    int         a     = int'(cfg_addr);
    bit         wr    = cfg_en && cfg_wen && !err;
    bit         cr    = cfg_en && !cfg_wen && !err && a == 140;
    int         order [4] = '{0, 11, 3, 7};
    int         nphase = m_phase;
    int         ncause = m_cause;
    bit         nclr;
    logic [7:0] np;
    if (m_phase == 0) begin
      for (int k = 0; k < 4; k++)
        if (m_qual(order[k])) begin ncause = order[k]; nphase = 1; break; end
    end else if (m_phase == 1) begin
      if (int_trap_ack) nphase = 2;
      else if (m_cause != 0 && !m_qual(m_cause)) nphase = 0;
    end else begin
      nphase = 0;
    end
    nclr = (m_phase == 1) && int_trap_ack && (m_cause == 0);
    m_nmip = (nmi && !m_nmiq) || (m_nmip && !nclr);
    for (int i = 0; i < NSRC; i++) begin
      if (EDGE[i])
        np[i] = (m_armed && src_irq[i] && !m_srcq[i]) ||
                (m_pend[i] && !((cr && w == i + 1) || (wr && a == 132 && cfg_wdata[i])));
      else
        np[i] = src_irq[i];
    end
    if (wr && a < 128) m_prio[a / 4] = int'(cfg_wdata[2:0]);
    if (wr && a == 128) m_en = cfg_wdata[7:0];
    if (wr && a == 136) m_thr = int'(cfg_wdata[2:0]);
    m_pend = np; m_srcq = src_irq; m_nmiq = nmi; m_armed = 1;
    m_phase = nphase; m_cause = ncause;
  endtask

  // Called at posedge+1 with inputs already driven; returns at next posedge+1.
  task automatic tick(string tag);
    #1;
    check_outputs(tag);
    model_step();
    @(posedge g_clk);
    #1;
  endtask

  task automatic wr(logic [7:0] a, logic [31:0] d);
    cfg_en = 1; cfg_wen = 1; cfg_addr = a; cfg_wdata = d;
    tick("wr");
    cfg_en = 0; cfg_wen = 0;
  endtask

  task automatic rd(string name, logic [7:0] a, logic [31:0] exp);
    cfg_en = 1; cfg_wen = 0; cfg_addr = a; cfg_wdata = 0;
    #1;
    chk(name, cfg_rdata, exp);
    tick("rd");
    cfg_en = 0;
  endtask

  typedef struct {
    bit          wen;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
  } vec_t;

  vec_t tbl [17];

  initial begin
    logic [7:0] alist [14];
    tbl[0]  = '{1, 8'h08, 32'd3,          32'd0, 0};
    tbl[1]  = '{0, 8'h08, 32'd0,          32'd3, 0};
    tbl[2]  = '{1, 8'h80, 32'hFFFF_FF04,  32'd0, 0};
    tbl[3]  = '{0, 8'h80, 32'd0,          32'h04, 0};
    tbl[4]  = '{1, 8'h88, 32'd9,          32'd0, 0};
    tbl[5]  = '{0, 8'h88, 32'd0,          32'd1, 0};
    tbl[6]  = '{0, 8'h90, 32'd0,          32'd0, 1};
    tbl[7]  = '{1, 8'h8C, 32'd5,          32'd0, 1};
    tbl[8]  = '{0, 8'h8C, 32'd0,          32'd0, 0};
    tbl[9]  = '{0, 8'h20, 32'd0,          32'd0, 1};
    tbl[10] = '{1, 8'h20, 32'd7,          32'd0, 1};
    tbl[11] = '{0, 8'h02, 32'd0,          32'd0, 1};
    tbl[12] = '{0, 8'h84, 32'd0,          32'd0, 0};
    tbl[13] = '{1, 8'h0C, 32'hF,          32'd0, 0};
    tbl[14] = '{0, 8'h0C, 32'd0,          32'd7, 0};
    tbl[15] = '{1, 8'h0C, 32'd0,          32'd0, 0};
    tbl[16] = '{0, 8'h88, 32'd0,          32'd1, 0};

    g_reset = 1; src_irq = 0; nmi = 0;
    mstatus_mie = 0; mie_meie = 0; mie_mtie = 0; mie_msie = 0;
    ti_pending = 0; sw_pending = 0; int_trap_ack = 0;
    cfg_en = 1; cfg_wen = 0; cfg_addr = 8'h90; cfg_wdata = 0;
    model_reset();

    // Reset state, access attempted during reset
    #2;
    chk("rst.req", int_trap_req, 0);
    chk("rst.cause", int_trap_cause, 0);
    chk("rst.err", cfg_error, 0);
    chk("rst.rdata", cfg_rdata, 0);
    chk("rst.meip", mip_meip, 0);
    cfg_en = 0;
    @(posedge g_clk); @(posedge g_clk); #1;
    g_reset = 0;
    tick("post_rst");

    // Table-driven register accesses (also covers unmapped / CLAIM write errors)
    foreach (tbl[k]) begin
      cfg_en = 1; cfg_wen = tbl[k].wen; cfg_addr = tbl[k].addr; cfg_wdata = tbl[k].wdata;
      #1;
      chk($sformatf("tbl%0d.err", k), cfg_error, tbl[k].err);
      if (!tbl[k].wen) chk($sformatf("tbl%0d.rdata", k), cfg_rdata, tbl[k].rdata);
      tick("tbl");
      cfg_en = 0; cfg_wen = 0;
    end

    // Level source 2 -> request two cycles later with cause 11, CLAIM = 3
    mstatus_mie = 1; mie_meie = 1; src_irq[2] = 1;
    tick("s39a");
    chk("s39.req_n1", int_trap_req, 0);
    chk("s39.meip_n1", mip_meip, 1);
    tick("s39b");
    chk("s39.req_n2", int_trap_req, 1);
    chk("s39.cause", int_trap_cause, 11);
    rd("s39.claim", 8'h8C, 3);
    src_irq[2] = 0; int_trap_ack = 1;
    tick("s39c");
    int_trap_ack = 0;
    tick("s39d"); tick("s39e");

    // Equal priorities tie to lowest index; threshold masks both
    mstatus_mie = 0;
    src_irq[1] = 1; src_irq[4] = 1;
    wr(8'h04, 5); wr(8'h10, 5); wr(8'h80, 32'h12);
    rd("s40.claim_tie", 8'h8C, 2);
    wr(8'h88, 5);
    rd("s40.claim_thr", 8'h8C, 0);
    chk("s40.meip", mip_meip, 0);
    src_irq[1] = 0; src_irq[4] = 0;
    wr(8'h88, 0);

    // Edge source 0: sticky, cleared by CLAIM, set beats write-1 clear
    wr(8'h00, 2); wr(8'h80, 32'h01);
    src_irq[0] = 1; tick("s41a");
    src_irq[0] = 0; tick("s41b"); tick("s41c");
    rd("s41.pend_sticky", 8'h84, 1);
    rd("s41.claim", 8'h8C, 1);
    rd("s41.pend_claimed", 8'h84, 0);
    src_irq[0] = 1;
    wr(8'h84, 1);
    src_irq[0] = 0;
    rd("s41.set_wins", 8'h84, 1);
    wr(8'h84, 1);
    rd("s41.w1c", 8'h84, 0);

    // Software before timer; HOLD gap; request drops when cause goes away
    mstatus_mie = 1; mie_meie = 0; mie_msie = 1; mie_mtie = 1;
    sw_pending = 1; ti_pending = 1;
    tick("s42a");
    chk("s42.req_sw", int_trap_req, 1);
    chk("s42.cause_sw", int_trap_cause, 3);
    int_trap_ack = 1; sw_pending = 0;
    tick("s42b");
    chk("s42.hold", int_trap_req, 0);
    int_trap_ack = 0;
    tick("s42c");
    chk("s42.idle", int_trap_req, 0);
    tick("s42d");
    chk("s42.req_tim", int_trap_req, 1);
    chk("s42.cause_tim", int_trap_cause, 7);
    ti_pending = 0;
    tick("s42e");
    chk("s42.drop", int_trap_req, 0);
    tick("s42f");

    // NMI ignores enables; ack clears it; async reset drops the request
    mstatus_mie = 0; mie_msie = 0; mie_mtie = 0;
    nmi = 1; tick("s43a");
    nmi = 0; tick("s43b");
    chk("s43.req_nmi", int_trap_req, 1);
    chk("s43.cause_nmi", int_trap_cause, 0);
    int_trap_ack = 1; tick("s43c");
    int_trap_ack = 0; tick("s43d"); tick("s43e");
    chk("s43.nmi_cleared", int_trap_req, 0);
    nmi = 1; tick("s43f");
    nmi = 0; tick("s43g");
    chk("s43.req_again", int_trap_req, 1);
    src_irq = 8'h09;
    g_reset = 1;
    #1;
    chk("s43.async_drop", int_trap_req, 0);
    chk("s43.async_cause", int_trap_cause, 0);
    model_reset();
    @(posedge g_clk); #1;
    g_reset = 0;

    // Lines high across reset release: level pends, edge waits for a new rise
    tick("s38a");
    rd("s38.level_only", 8'h84, 8'h08);
    rd("s38.still_level", 8'h84, 8'h08);
    src_irq[0] = 0; tick("s38b");
    src_irq[0] = 1; tick("s38c");
    rd("s38.edge_rise", 8'h84, 8'h09);
    src_irq = 0;

    // Randomized traffic against the reference model
    alist = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h1C, 8'h20, 8'h80,
              8'h84, 8'h88, 8'h8C, 8'h90, 8'h02, 8'h84};
    for (int n = 0; n < 600; n++) begin
      src_irq      = 8'($urandom);
      nmi          = ($urandom % 20) == 0;
      mstatus_mie  = ($urandom % 4) != 0;
      mie_meie     = ($urandom % 3) != 0;
      mie_msie     = ($urandom % 2) != 0;
      mie_mtie     = ($urandom % 2) != 0;
      sw_pending   = ($urandom % 5) == 0;
      ti_pending   = ($urandom % 5) == 0;
      int_trap_ack = ($urandom % 3) == 0;
      cfg_en       = ($urandom % 2) != 0;
      cfg_wen      = ($urandom % 3) == 0;
      cfg_addr     = alist[$urandom_range(0, 13)];
      cfg_wdata    = $urandom;
      tick("rnd");
    end
    cfg_en = 0; int_trap_ack = 0;
    tick("end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
